spike_adder_tree: RTL and testbench

Pipelined, parametrised N-input adder tree with a per-input enable mask and valid/ready flow control. It sums N equal-width operands, for example the weighted spike contributions feeding an ODESA neuron, at one result per cycle. Each tree level has a register stage, so the block closes timing at widths and channel counts where a single combinational adder cannot.

---
 rtl/spike_adder_tree_pkg.sv | 25 ++
 rtl/spike_adder_tree_if.sv | 31 +++
 rtl/spike_adder_tree_level.sv | 55 +++++
 rtl/spike_adder_tree.sv | 73 +++++++
 tb/tb_spike_adder_tree.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spike_adder_tree_pkg.sv
// spike_adder_tree_pkg
//   Shared helpers for the pipelined adder tree:
//     clog2      - ceiling log2 used to size the tree
//     lvl_w      - operand width at tree level j (input width + j)
//     num_levels - number of register levels for a given operand count
package spike_adder_tree_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int lvl_w(input int input_width, input int j);
        return input_width + j;
    endfunction

    function automatic int num_levels(input int num_inputs);
        return clog2(num_inputs);
    endfunction

endpackage

// File: rtl/spike_adder_tree_if.sv
// spike_adder_tree_if
//   Operand/result channel of the adder tree.
//     i_data/i_mask/i_valid/o_ready : operand beat in (valid/ready)
//     o_s/o_valid/i_ready           : sum out (valid/ready)
//   master drives operands and accepts sums; slave is the tree.
interface spike_adder_tree_if
    import spike_adder_tree_pkg::*;
#(
    parameter int P_INPUT_WIDTH = 14,
    parameter int P_NUM_INPUTS  = 8
) ();
    localparam int SUM_W = P_INPUT_WIDTH + clog2(P_NUM_INPUTS);

    logic [P_NUM_INPUTS*P_INPUT_WIDTH-1:0] i_data;
    logic [P_NUM_INPUTS-1:0]               i_mask;
    logic                                  i_valid;
    logic                                  o_ready;
    logic [SUM_W-1:0]                      o_s;
    logic                                  o_valid;
    logic                                  i_ready;

    modport master (
        output i_data, i_mask, i_valid, i_ready,
        input  o_ready, o_s, o_valid
    );

    modport slave (
        input  i_data, i_mask, i_valid, i_ready,
        output o_ready, o_s, o_valid
    );
endinterface

// File: rtl/spike_adder_tree_level.sv
// spike_adder_tree_level
//   One registered level of the tree: adds adjacent operand pairs, each sum
//   one bit wider than its operands, and registers the sums with a valid bit.
//   Ports:
//     i_clk, i_rst  - clock, synchronous active-high reset
//     i_adv         - pipeline advance; level holds when low
//     i_data        - 2*P_PAIRS operands of P_IN_W bits
//     i_valid       - valid bit travelling with i_data
//     o_data        - P_PAIRS registered sums of P_IN_W+1 bits
//     o_valid       - registered valid bit
//   SPIKE_ADDER_TREE_SIGNED_EN selects sign extension instead of zero extension.
module spike_adder_tree_level #(
    parameter int P_IN_W  = 14,
    parameter int P_PAIRS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_adv,
    input  logic [2*P_PAIRS*P_IN_W-1:0]   i_data,
    input  logic                          i_valid,
    output logic [P_PAIRS*(P_IN_W+1)-1:0] o_data,
    output logic                          o_valid
);
    localparam int OUT_W = P_IN_W + 1;

    logic [P_PAIRS*OUT_W-1:0] sum;

    for (genvar p = 0; p < P_PAIRS; p++) begin : g_pair
        logic [P_IN_W-1:0] a;
        logic [P_IN_W-1:0] b;
        logic [OUT_W-1:0]  a_ext;
        logic [OUT_W-1:0]  b_ext;

        assign a = i_data[(2*p)*P_IN_W +: P_IN_W];
        assign b = i_data[(2*p+1)*P_IN_W +: P_IN_W];
`ifdef SPIKE_ADDER_TREE_SIGNED_EN
        assign a_ext = {a[P_IN_W-1], a};
        assign b_ext = {b[P_IN_W-1], b};
`else
        assign a_ext = {1'b0, a};
        assign b_ext = {1'b0, b};
`endif
        assign sum[p*OUT_W +: OUT_W] = a_ext + b_ext;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (i_adv) begin
            o_data  <= sum;
            o_valid <= i_valid;
        end
    end
endmodule

// File: rtl/spike_adder_tree.sv
// spike_adder_tree
//   Pipelined N-input adder tree with per-operand enable mask and valid/ready
//   flow control. One register level per tree level, so latency is
//   log2(P_NUM_INPUTS) cycles and throughput one beat per cycle.
//   Ports:
//     i_clk, i_rst - clock, synchronous active-high reset
//     bus          - spike_adder_tree_if.slave (operands in, sum out)
//   Build option: define SPIKE_ADDER_TREE_SIGNED_EN for two's complement
//   operands and result; default is unsigned.
module spike_adder_tree
    import spike_adder_tree_pkg::*;
#(
    parameter int P_INPUT_WIDTH = 14,
    parameter int P_NUM_INPUTS  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spike_adder_tree_if.slave    bus
);
    localparam int W = P_INPUT_WIDTH;
    localparam int L = num_levels(P_NUM_INPUTS);

    logic                      adv;
    logic [P_NUM_INPUTS*W-1:0] masked;

    // Whole pipeline is one stall domain: it moves whenever the output
    // register is empty or being drained this cycle.
    assign adv         = ~bus.o_valid | bus.i_ready;
    assign bus.o_ready = adv;

    always_comb begin
        masked = '0;
        for (int k = 0; k < P_NUM_INPUTS; k++) begin
            if (bus.i_mask[k]) begin
                masked[k*W +: W] = bus.i_data[k*W +: W];
            end
        end
    end

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        localparam int IN_W  = lvl_w(W, j - 1);
        localparam int PAIRS = P_NUM_INPUTS >> j;

        logic [2*PAIRS*IN_W-1:0]   src_data;
        logic                      src_valid;
        logic [PAIRS*(IN_W+1)-1:0] data;
        logic                      valid;

        if (j == 1) begin : g_src
            assign src_data  = masked;
            assign src_valid = bus.i_valid;
        end else begin : g_src
            assign src_data  = g_lvl[j-1].data;
            assign src_valid = g_lvl[j-1].valid;
        end

        spike_adder_tree_level #(
            .P_IN_W  (IN_W),
            .P_PAIRS (PAIRS)
        ) u_level (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_adv   (adv),
            .i_data  (src_data),
            .i_valid (src_valid),
            .o_data  (data),
            .o_valid (valid)
        );
    end

    assign bus.o_s     = g_lvl[L].data;
    assign bus.o_valid = g_lvl[L].valid;
endmodule

// File: tb/tb_spike_adder_tree.sv
module tb_spike_adder_tree;
    localparam int W   = 14;
    localparam int N   = 8;
    localparam int L   = 3;
    localparam int SW  = W + L;
    localparam int W2  = 8;
    localparam int N2  = 64;
    localparam int SW2 = W2 + 6;

    typedef struct {
        logic [SW-1:0] s;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_stall = -1;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spike_adder_tree_if #(.P_INPUT_WIDTH(W), .P_NUM_INPUTS(N)) bus ();
    spike_adder_tree_if #(.P_INPUT_WIDTH(W2), .P_NUM_INPUTS(N2)) bus64 ();

    spike_adder_tree #(.P_INPUT_WIDTH(W), .P_NUM_INPUTS(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    spike_adder_tree #(.P_INPUT_WIDTH(W2), .P_NUM_INPUTS(N2)) u_big (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer sum of the enabled operands, wrapped to the
    // output width (exact, since the output is wide enough for N operands).
    function automatic logic [SW-1:0] ref_sum(input logic [N*W-1:0] d, input logic [N-1:0] m);
        longint acc;
        longint v;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            if (m[k]) begin
                v = longint'(d[k*W +: W]);
`ifdef SPIKE_ADDER_TREE_SIGNED_EN
                if (d[k*W + W - 1]) v = v - (longint'(1) << W);
`endif
                acc = acc + v;
            end
        end
        return acc[SW-1:0];
    endfunction

    task automatic step(input logic v, input logic [N*W-1:0] d, input logic [N-1:0] m,
                        input logic rdy, output logic acc);
        exp_t e;
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_mask  = m;
        bus.i_ready = rdy;
        #1;
        acc = v && bus.o_ready && !rst;
        if (acc) begin
            e.s   = ref_sum(d, m);
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic reset_pulse(input int n);
        repeat (n) begin
            @(negedge clk);
            rst         = 1'b1;
            bus.i_valid = 1'b1;
            bus.i_ready = 1'b1;
            q.delete();
        end
    endtask

    // Monitor / scoreboard
    bit            armed = 0;
    bit            after_rst = 0;
    bit            prev_stall = 0;
    logic [SW-1:0] prev_s;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                armed = 1;
                after_rst = 1;
                prev_stall = 0;
                continue;
            end
            if (!armed) continue;
            if (after_rst) begin
                chk("rst_o_valid", 64'(bus.o_valid), 64'(0));
                chk("rst_o_s", 64'(bus.o_s), 64'(0));
                chk("rst_o_ready", 64'(bus.o_ready), 64'(1));
                after_rst = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.o_valid), 64'(1));
                chk("stall_hold", 64'(bus.o_s), 64'(prev_s));
            end
            chk("o_ready", 64'(bus.o_ready), 64'(!(bus.o_valid && !bus.i_ready)));
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b0) last_stall = cyc;
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.o_s), 64'(0));
                    if (bus.o_s === '0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got valid beat, expected none (cycle %0d)", cyc);
                    end
                end else begin
                    e = q.pop_front();
                    chk("sum", 64'(bus.o_s), 64'(e.s));
                    if (last_stall < e.cyc) chk("latency", 64'(cyc - e.cyc), 64'(L));
                end
            end
            prev_stall = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
            prev_s = bus.o_s;
        end
    end

    // Wide configuration: 64 operands of 8 bits, six levels.
    initial begin
        int k;
        bus64.i_valid = 1'b0;
        bus64.i_data  = '0;
        bus64.i_mask  = '0;
        bus64.i_ready = 1'b1;
        wait (rst == 1'b0);
        @(negedge clk);
        bus64.i_valid = 1'b1;
        bus64.i_data  = '1;
        bus64.i_mask  = '1;
        @(negedge clk);
        bus64.i_valid = 1'b0;
        for (k = 1; k <= 20; k++) begin
            #2;
            if (bus64.o_valid === 1'b1) break;
            @(negedge clk);
        end
        chk("big_latency", 64'(k), 64'(6));
        // 64*255; the two's complement reading (64 * -1) wraps to the same bits.
        chk("big_sum", 64'(bus64.o_s), 64'((64 * 255) % (1 << SW2)));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [N*W-1:0] d;
    logic [N-1:0]   m;
    logic           a;
    int             n;

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_mask  = '0;
        bus.i_ready = 1'b1;
        reset_pulse(2);

        // All operands at full scale
        d = '1;
        step(1'b1, d, 8'hFF, 1'b1, a);
        repeat (6) step(1'b0, '0, '0, 1'b1, a);

        // Values 1..8 under a sparse mask, then fully masked
        for (int k = 0; k < N; k++) d[k*W +: W] = 14'(k + 1);
        step(1'b1, d, 8'b1010_0101, 1'b1, a);
        step(1'b1, d, 8'h00, 1'b1, a);
        repeat (6) step(1'b0, '0, '0, 1'b1, a);

        // Counting stream with a 5-cycle downstream stall
        n = 0;
        for (int c = 0; c < 80 && n < 20; c++) begin
            d = '0;
            d[W-1:0] = 14'(n);
            step(1'b1, d, 8'hFF, !(c >= 8 && c < 13), a);
            if (a) n++;
        end
        chk("stream_accepted", 64'(n), 64'(20));
        repeat (6) step(1'b0, '0, '0, 1'b1, a);

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < N; k++) d[k*W +: W] = 14'($urandom);
            m = 8'($urandom);
            step($urandom_range(0, 3) != 0, d, m, $urandom_range(0, 9) < 7, a);
        end

        // Reset while beats are in flight
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < N; k++) d[k*W +: W] = 14'($urandom);
            step(1'b1, d, 8'hFF, 1'b1, a);
        end
        reset_pulse(1);
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < N; k++) d[k*W +: W] = 14'($urandom);
            m = 8'($urandom);
            step($urandom_range(0, 1) != 0, d, m, $urandom_range(0, 3) != 0, a);
        end

        // Drain
        for (int k = 0; k < 50 && q.size() > 0; k++) step(1'b0, '0, '0, 1'b1, a);
        repeat (3) step(1'b0, '0, '0, 1'b1, a);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
